// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: turns one M-stage access into a single req/ack
// transaction, stalls the pipeline until the responder answers (or the ack
// timeout expires), and returns the extended load result.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; aligned req_valid is accepted on the next edge
// WAIT  | m_req high, bus outputs frozen, waiting for m_ack or timeout
// RESP  | one cycle with stall low so the pipeline advances past M
module lsu_bus_master #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        align_err,
    output logic        bus_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] T_WORD  = 2'b00;
    localparam logic [1:0] T_BYTE  = 2'b01;
    localparam logic [1:0] T_BYTEU = 2'b10;
    localparam logic [1:0] T_HALF  = 2'b11;

    // The counter starts at 0 in the first WAIT cycle, so matching
    // ACK_TIMEOUT-1 aborts after exactly ACK_TIMEOUT WAIT cycles.
    localparam bit              TO_EN    = (ACK_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(ACK_TIMEOUT - 1) : '0;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       type_q;
    logic [1:0]       off_q;

    logic             misaligned;
    logic             accept;
    logic [3:0]       byteen_d;
    logic [31:0]      wdata_d;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [31:0]      load_d;

    // Alignment check, lane enables and replicated store data for the request
    always_comb begin
        misaligned = 1'b0;
        byteen_d   = 4'b0001 << req_addr[1:0];
        wdata_d    = {4{req_wdata[7:0]}};
        case (req_type)
            T_WORD: begin
                misaligned = (req_addr[1:0] != 2'b00);
                byteen_d   = 4'b1111;
                wdata_d    = req_wdata;
            end
            T_HALF: begin
                misaligned = req_addr[0];
                byteen_d   = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Pipeline-facing handshake: only IDLE looks at a new request
    always_comb begin
        align_err = (state == S_IDLE) && req_valid && misaligned;
        accept    = (state == S_IDLE) && req_valid && !misaligned;
        stall     = accept || (state == S_WAIT);
    end

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        case (off_q)
            2'd0:    lane_byte = m_rdata[7:0];
            2'd1:    lane_byte = m_rdata[15:8];
            2'd2:    lane_byte = m_rdata[23:16];
            default: lane_byte = m_rdata[31:24];
        endcase
        lane_half = off_q[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (type_q)
            T_BYTE:  load_d = {{24{lane_byte[7]}}, lane_byte};
            T_BYTEU: load_d = {24'd0, lane_byte};
            T_HALF:  load_d = {{16{lane_half[15]}}, lane_half};
            default: load_d = m_rdata;
        endcase
    end

    // Transaction FSM, bus output registers, timeout counter and load result
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= S_IDLE;
            cnt         <= '0;
            type_q      <= T_WORD;
            off_q       <= 2'd0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_byteen    <= '0;
            m_wdata     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        m_req    <= 1'b1;
                        m_we     <= req_we;
                        m_addr   <= {req_addr[31:2], 2'b00};
                        m_byteen <= byteen_d;
                        m_wdata  <= wdata_d;
                        type_q   <= req_type;
                        off_q    <= req_addr[1:0];
                        cnt      <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        state <= S_RESP;
                        if (!m_we) begin
                            rdata       <= load_d;
                            rdata_valid <= 1'b1;
                        end
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        m_req   <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    rdata_valid <= 1'b0;
                    bus_err     <= 1'b0;
                    cnt         <= '0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed vector table, randomized
// transactions against a byte-lane reference model, and hand-written
// sequences for misalignment, clr abort and ack timeout.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid, req_we;
    logic [1:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rdata_valid, align_err, bus_err;
    logic [31:0] rdata;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_byteen;

    logic        t_stall, t_rdata_valid, t_align_err, t_bus_err;
    logic [31:0] t_rdata;
    logic        t_m_req, t_m_we, t_ack;
    logic [31:0] t_m_addr, t_m_wdata;
    logic [3:0]  t_m_byteen;

    int total = 0;
    int bad   = 0;
    logic [31:0] cur_rd;

    always #5 clk = ~clk;

    lsu_bus_master dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .align_err(align_err), .bus_err(bus_err), .m_req(m_req), .m_we(m_we),
        .m_addr(m_addr), .m_byteen(m_byteen), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    lsu_bus_master #(.ACK_TIMEOUT(3)) dut_to (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(t_stall), .rdata(t_rdata), .rdata_valid(t_rdata_valid),
        .align_err(t_align_err), .bus_err(t_bus_err), .m_req(t_m_req), .m_we(t_m_we),
        .m_addr(t_m_addr), .m_byteen(t_m_byteen), .m_wdata(t_m_wdata),
        .m_ack(t_ack), .m_rdata(m_rdata)
    );

    typedef struct {
        logic        we;
        logic [1:0]  ty;
        logic [31:0] addr;
        logic [31:0] wd;
        int          delay;
        logic [31:0] word;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: an access covers `size` bytes starting at the address
    // rounded down to size; lanes are little-endian bytes of the bus word.
    function automatic int msize(input logic [1:0] ty);
        case (ty)
            2'b00:   return 4;
            2'b11:   return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int mbase(input logic [1:0] ty, input logic [31:0] addr);
        int off = int'(addr[1:0]);
        return off - (off % msize(ty));
    endfunction

    function automatic logic [3:0] mbe(input logic [1:0] ty, input logic [31:0] addr);
        logic [3:0] r = '0;
        int b = mbase(ty, addr);
        for (int i = 0; i < 4; i++)
            if (i >= b && i < b + msize(ty)) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] mwd(input logic [1:0] ty, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = wd[8*(i % msize(ty)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mld(input logic [1:0] ty, input logic [31:0] addr,
                                        input logic [31:0] word);
        longint v = 0;
        int s = msize(ty);
        int b = mbase(ty, addr);
        for (int k = 0; k < s; k++)
            v = v | (longint'(word[8*(b+k) +: 8]) << (8*k));
        if ((ty == 2'b01 || ty == 2'b11) && v >= (longint'(1) << (8*s - 1)))
            v = v - (longint'(1) << (8*s));
        return v[31:0];
    endfunction

    // Runs one aligned transaction; the responder acks in WAIT cycle `delay`.
    // Starts and ends one time unit after a rising edge.
    task automatic run_txn(input string nm, input logic we, input logic [1:0] ty,
                           input logic [31:0] addr, input logic [31:0] wd, input int delay,
                           input logic [31:0] word, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        int stall_n = 0, req_n = 0, rv_n = 0, waitn = 0, bad_hold = 0;
        logic done = 1'b0;
        req_valid = 1'b1; req_we = we; req_type = ty; req_addr = addr; req_wdata = wd;
        for (int c = 0; c < 64 && !done; c++) begin
            if (m_req) waitn++;
            m_ack   = m_req && (waitn == delay);
            m_rdata = m_ack ? word : $urandom;
            #1;
            if (rdata_valid) rv_n++;
            if (m_req) begin
                req_n++;
                if (m_addr !== {addr[31:2], 2'b00} || m_we !== we ||
                    m_byteen !== exp_be || m_wdata !== exp_wd) bad_hold++;
            end
            if (stall) stall_n++;
            else if (stall_n > 0) begin
                done = 1'b1;
                chk({nm, "_rdata"}, rdata, exp_rd);
            end
            @(posedge clk); #1;
        end
        m_ack = 1'b0;
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_stall_cycles"}, 32'(stall_n), 32'(delay + 1));
        chk({nm, "_req_cycles"}, 32'(req_n), 32'(delay));
        chk({nm, "_bus_fields"}, 32'(bad_hold), 32'd0);
        chk({nm, "_rvalid_pulses"}, 32'(rv_n), we ? 32'd0 : 32'd1);
    endtask

    task automatic mis_txn(input string nm, input logic [1:0] ty, input logic [31:0] addr);
        int req_n = 0;
        req_valid = 1'b1; req_we = 1'b0; req_type = ty; req_addr = addr;
        #1;
        chk({nm, "_align_err"}, 32'(align_err), 32'd1);
        chk({nm, "_stall"}, 32'(stall), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (m_req) req_n++;
        end
        chk({nm, "_m_req_cycles"}, 32'(req_n), 32'd0);
        req_valid = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        clr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 2'b00;
        req_addr = '0; req_wdata = '0; m_ack = 1'b0; m_rdata = '0; t_ack = 1'b0;

        vecs[0] = '{1'b0, 2'b00, 32'h0000_0010, 32'h1234_5678, 1, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 2'b01, 32'h0000_0013, 32'h0000_00A5, 1, 32'h0000_0000, 4'h8, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 2'b01, 32'h0000_0103, 32'h0000_0000, 1, 32'h80F1_7F01, 4'h8, 32'h0000_0000, 32'hFFFF_FF80};
        vecs[3] = '{1'b0, 2'b10, 32'h0000_0103, 32'h0000_0000, 2, 32'h80F1_7F01, 4'h8, 32'h0000_0000, 32'h0000_0080};
        vecs[4] = '{1'b0, 2'b11, 32'h0000_0102, 32'h0000_0000, 1, 32'h80F1_7F01, 4'hC, 32'h0000_0000, 32'hFFFF_80F1};
        vecs[5] = '{1'b0, 2'b11, 32'h0000_0100, 32'h0000_0000, 3, 32'h80F1_7F01, 4'h3, 32'h0000_0000, 32'h0000_7F01};
        vecs[6] = '{1'b0, 2'b01, 32'h0000_0101, 32'h0000_0000, 1, 32'h80F1_7F01, 4'h2, 32'h0000_0000, 32'h0000_007F};
        vecs[7] = '{1'b1, 2'b11, 32'h0000_0202, 32'hFFFF_1234, 2, 32'h0000_0000, 4'hC, 32'h1234_1234, 32'h0000_007F};
        vecs[8] = '{1'b0, 2'b00, 32'h0000_0020, 32'h0000_0000, 5, 32'h0BAD_F00D, 4'hF, 32'h0000_0000, 32'h0BAD_F00D};
        vecs[9] = '{1'b1, 2'b10, 32'h0000_0030, 32'h0000_01C3, 1, 32'h0000_0000, 4'h1, 32'hC3C3_C3C3, 32'h0BAD_F00D};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_m_req", 32'(m_req), 32'd0);
        chk("reset_m_we", 32'(m_we), 32'd0);
        chk("reset_m_addr", m_addr, 32'd0);
        chk("reset_m_byteen", 32'(m_byteen), 32'd0);
        chk("reset_m_wdata", m_wdata, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("reset_bus_err", 32'(bus_err), 32'd0);
        clr = 1'b0;

        // Directed vectors, issued back to back
        for (int i = 0; i < 10; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].ty, vecs[i].addr, vecs[i].wd,
                    vecs[i].delay, vecs[i].word, vecs[i].exp_be, vecs[i].exp_wd, vecs[i].exp_rd);
        cur_rd = 32'h0BAD_F00D;

        mis_txn("mis_lw6", 2'b00, 32'h0000_0006);
        mis_txn("mis_lh3", 2'b11, 32'h0000_0003);
        chk("mis_rdata_kept", rdata, cur_rd);

        // Randomized traffic checked against the byte-lane model
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [1:0]  ty;
            logic [31:0] addr, wd, word;
            we   = 1'($urandom_range(0, 1));
            ty   = 2'($urandom_range(0, 3));
            addr = $urandom;
            wd   = $urandom;
            word = $urandom;
            if (ty == 2'b00) addr[1:0] = 2'b00;
            if (ty == 2'b11) addr[0] = 1'b0;
            if (!we) cur_rd = mld(ty, addr, word);
            run_txn($sformatf("rnd%0d", i), we, ty, addr, wd, $urandom_range(1, 4), word,
                    mbe(ty, addr), mwd(ty, wd), cur_rd);
        end

        // clr in the second WAIT cycle aborts the load; a late ack is ignored
        begin
            int rv_n = 0, req_n = 0;
            req_valid = 1'b1; req_we = 1'b0; req_type = 2'b00;
            req_addr = 32'h0000_0054; req_wdata = 32'h5555_AAAA;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("clr_pre_m_req", 32'(m_req), 32'd1);
            clr = 1'b1; req_valid = 1'b0;
            @(posedge clk); #1;
            clr = 1'b0; m_ack = 1'b1; m_rdata = 32'h1357_9BDF;
            #1;
            chk("clr_m_req", 32'(m_req), 32'd0);
            chk("clr_m_addr", m_addr, 32'd0);
            chk("clr_m_byteen", 32'(m_byteen), 32'd0);
            chk("clr_m_wdata", m_wdata, 32'd0);
            chk("clr_rdata", rdata, 32'd0);
            chk("clr_stall", 32'(stall), 32'd0);
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                if (rdata_valid) rv_n++;
                if (m_req) req_n++;
            end
            m_ack = 1'b0;
            chk("clr_late_ack_rvalid", 32'(rv_n), 32'd0);
            chk("clr_late_ack_m_req", 32'(req_n), 32'd0);
            chk("clr_late_ack_rdata", rdata, 32'd0);
        end

        // Timeout instance (ACK_TIMEOUT=3) never sees an ack
        begin
            int be_n = 0, req_n = 0, stall_n = 0, first = -1;
            logic seen = 1'b0;
            clr = 1'b1;
            @(posedge clk); #1;
            clr = 1'b0;
            req_valid = 1'b1; req_we = 1'b0; req_type = 2'b00; req_addr = 32'h0000_0040;
            for (int c = 0; c < 40 && !seen; c++) begin
                #1;
                if (t_stall) stall_n++;
                if (t_m_req) req_n++;
                if (t_bus_err) begin
                    seen = 1'b1; first = c; be_n++;
                    chk("to_m_req_dropped", 32'(t_m_req), 32'd0);
                    chk("to_stall_released", 32'(t_stall), 32'd0);
                end
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                #1;
                if (t_bus_err) be_n++;
                if (t_m_req) req_n++;
                @(posedge clk); #1;
            end
            chk("to_seen", 32'(seen), 32'd1);
            chk("to_first_cycle", 32'(first), 32'd4);
            chk("to_pulses", 32'(be_n), 32'd1);
            chk("to_req_cycles", 32'(req_n), 32'd3);
            chk("to_stall_cycles", 32'(stall_n), 32'd4);
            chk("to_rdata_kept", t_rdata, 32'd0);
            chk("to_rvalid", 32'(t_rdata_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
